// File: rtl/mc_array_rsp.sv
// mc_array_rsp: responder for a row/column array interface.
// A row is opened while array_cs_n is low. Write columns are queued in a
// 4-entry FIFO and consumed by write-data strobes. Read columns return data
// through a fixed-latency pipeline. Protocol violations raise sticky flags.
module mc_array_rsp #(
    parameter int ARRAY_ROW_ADDR_WIDTH = 16,
    parameter int ARRAY_COL_ADDR_WIDTH = 6,
    parameter int ARRAY_DATA_WIDTH     = 64,
    parameter int ROW_STORE_BITS       = 2,
    parameter int RD_LAT               = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            array_cs_n,
    input  logic [ARRAY_ROW_ADDR_WIDTH-1:0] array_raddr,
    input  logic                            array_caddr_vld_wr,
    input  logic [ARRAY_COL_ADDR_WIDTH-1:0] array_caddr_wr,
    input  logic                            array_caddr_vld_rd,
    input  logic [ARRAY_COL_ADDR_WIDTH-1:0] array_caddr_rd,
    input  logic                            array_wdata_vld,
    input  logic [ARRAY_DATA_WIDTH-1:0]     array_wdata,
    output logic                            array_rdata_vld,
    output logic [ARRAY_DATA_WIDTH-1:0]     array_rdata,
    output logic                            err_wr_ovf,
    output logic                            err_wr_unf,
    output logic                            err_proto
);

    localparam int IDX_W = ROW_STORE_BITS + ARRAY_COL_ADDR_WIDTH;
    localparam int WORDS = 1 << IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_PRECHARGE
    } state_t;

    state_t state, state_nxt;
    logic   pre_cnt;

    logic [ARRAY_ROW_ADDR_WIDTH-1:0] open_row;

    logic [ARRAY_COL_ADDR_WIDTH-1:0] fifo_mem [4];
    logic [1:0]                      wr_ptr, rd_ptr;
    logic [2:0]                      fifo_cnt, fifo_cnt_nxt;

    logic [ARRAY_DATA_WIDTH-1:0] mem [WORDS];

    logic [RD_LAT-1:0]           vld_pipe;
    logic [ARRAY_DATA_WIDTH-1:0] data_pipe [RD_LAT];

    logic                            active, leave;
    logic                            fifo_empty, fifo_full;
    logic                            bypass, pop, push, rd_en, wr_en;
    logic                            ovf_evt, unf_evt, flush_evt, proto_evt;
    logic [ARRAY_COL_ADDR_WIDTH-1:0] wr_col;
    logic [IDX_W-1:0]                wr_idx, rd_idx;

    // Rows above the stored range alias onto stored rows, so the upper
    // open_row bits are kept for visibility but never used for addressing.
    logic unused_row_bits;
    assign unused_row_bits = ^open_row[ARRAY_ROW_ADDR_WIDTH-1:ROW_STORE_BITS];

    // Next-state logic for the row FSM.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt; no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE:      if (!array_cs_n) state_nxt = ST_ACTIVE;
            ST_ACTIVE:    if (array_cs_n)  state_nxt = ST_PRECHARGE;
            ST_PRECHARGE: if (pre_cnt)     state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    // Row FSM state, precharge counter and open-row latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            state    <= ST_IDLE;
            pre_cnt  <= 1'b0;
            open_row <= '0;
        end else begin
            state   <= state_nxt;
            pre_cnt <= (state == ST_PRECHARGE) ? ~pre_cnt : 1'b0;
            if (state == ST_IDLE && !array_cs_n) open_row <= array_raddr;
        end
    end

    // Write-column FIFO decisions, storage addressing and error events.
    always_comb begin
        active     = (state == ST_ACTIVE);
        leave      = active && array_cs_n;
        fifo_empty = (fifo_cnt == 3'd0);
        fifo_full  = (fifo_cnt == 3'd4);

        bypass  = active && array_caddr_vld_wr && array_wdata_vld && fifo_empty;
        pop     = active && array_wdata_vld && !fifo_empty;
        push    = active && array_caddr_vld_wr && !bypass && (!fifo_full || pop);
        ovf_evt = active && array_caddr_vld_wr && fifo_full && !pop;
        unf_evt = active && array_wdata_vld && fifo_empty && !array_caddr_vld_wr;

        fifo_cnt_nxt = fifo_cnt + 3'(push) - 3'(pop);
        flush_evt    = leave && (fifo_cnt_nxt != 3'd0);

        wr_en  = bypass || pop;
        wr_col = bypass ? array_caddr_wr : fifo_mem[rd_ptr];
        wr_idx = {open_row[ROW_STORE_BITS-1:0], wr_col};
        rd_en  = active && array_caddr_vld_rd;
        rd_idx = {open_row[ROW_STORE_BITS-1:0], array_caddr_rd};

        proto_evt = (!active && (array_caddr_vld_wr || array_caddr_vld_rd || array_wdata_vld))
                 || (state == ST_PRECHARGE && !array_cs_n);
    end

    // FIFO pointers and occupancy; leaving the row flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else if (leave) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt_nxt;
        end
    end

    // Array storage and FIFO entries.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; contents survive rst_n and only the write port changes them.
        if (rst_n && wr_en) mem[wr_idx]      <= array_wdata;
        if (rst_n && push)  fifo_mem[wr_ptr] <= array_caddr_wr;
    end

    // Read pipeline: stage 0 captures pre-write storage, each later stage
    // loads only when valid data arrives so the last stage holds its value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) data_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= rd_en;
            if (rd_en) data_pipe[0] <= mem[rd_idx];
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign array_rdata_vld = vld_pipe[RD_LAT-1];
    assign array_rdata     = data_pipe[RD_LAT-1];

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_wr_ovf <= 1'b0;
            err_wr_unf <= 1'b0;
            err_proto  <= 1'b0;
        end else begin
            if (ovf_evt)              err_wr_ovf <= 1'b1;
            if (unf_evt || flush_evt) err_wr_unf <= 1'b1;
            if (proto_evt)            err_proto  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_array_rsp.sv
// Directed testbench for mc_array_rsp with default parameters (RD_LAT = 2).
module tb_mc_array_rsp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        array_cs_n;
    logic [15:0] array_raddr;
    logic        array_caddr_vld_wr;
    logic [5:0]  array_caddr_wr;
    logic        array_caddr_vld_rd;
    logic [5:0]  array_caddr_rd;
    logic        array_wdata_vld;
    logic [63:0] array_wdata;
    logic        array_rdata_vld;
    logic [63:0] array_rdata;
    logic        err_wr_ovf;
    logic        err_wr_unf;
    logic        err_proto;

    int checks = 0;
    int errors = 0;

    mc_array_rsp dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .array_cs_n         (array_cs_n),
        .array_raddr        (array_raddr),
        .array_caddr_vld_wr (array_caddr_vld_wr),
        .array_caddr_wr     (array_caddr_wr),
        .array_caddr_vld_rd (array_caddr_vld_rd),
        .array_caddr_rd     (array_caddr_rd),
        .array_wdata_vld    (array_wdata_vld),
        .array_wdata        (array_wdata),
        .array_rdata_vld    (array_rdata_vld),
        .array_rdata        (array_rdata),
        .err_wr_ovf         (err_wr_ovf),
        .err_wr_unf         (err_wr_unf),
        .err_proto          (err_proto)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        array_caddr_vld_wr = 1'b0;
        array_caddr_vld_rd = 1'b0;
        array_wdata_vld    = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        array_cs_n = 1'b1;
        clear_strobes();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic open_row(input logic [15:0] addr);
        array_raddr = addr;
        array_cs_n  = 1'b0;
        step();
    endtask

    task automatic close_row();
        array_cs_n = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic write_col(input logic [5:0] col, input logic [63:0] data);
        array_caddr_vld_wr = 1'b1;
        array_caddr_wr     = col;
        array_wdata_vld    = 1'b1;
        array_wdata        = data;
        step();
        clear_strobes();
    endtask

    // Issues one read and reports: valid one cycle early, valid at latency,
    // data at latency, and whether the cycle after shows vld low with data held.
    task automatic read_col(input logic [5:0] col, output logic early, output logic hit,
                            output logic [63:0] data, output logic held);
        array_caddr_vld_rd = 1'b1;
        array_caddr_rd     = col;
        step();
        array_caddr_vld_rd = 1'b0;
        early = array_rdata_vld;
        step();
        hit  = array_rdata_vld;
        data = array_rdata;
        step();
        held = !array_rdata_vld && (array_rdata === data);
    endtask

    task automatic test_reset();
        apply_reset();
        if ({array_rdata_vld, array_rdata, err_wr_ovf, err_wr_unf, err_proto} !== 68'd0) begin
            $display("FAIL reset_outputs vld=%0b rdata=%h ovf=%0b unf=%0b proto=%0b expected all 0",
                     array_rdata_vld, array_rdata, err_wr_ovf, err_wr_unf, err_proto);
            errors++;
        end
        checks++;
    endtask

    task automatic test_basic_bypass();
        logic early, hit, held;
        logic [63:0] data;
        open_row(16'h0001);
        write_col(6'd5, 64'hA5A5_0000_0000_5A5A);
        read_col(6'd5, early, hit, data, held);
        if (early || !hit || data !== 64'hA5A5_0000_0000_5A5A) begin
            $display("FAIL basic_read early=%0b vld=%0b data=%h expected vld at cycle 2 data=a5a500000000 5a5a",
                     early, hit, data);
            errors++;
        end
        checks++;
        if (!held) begin
            $display("FAIL rdata_hold vld=%0b rdata=%h expected vld 0 rdata %h", array_rdata_vld,
                     array_rdata, data);
            errors++;
        end
        checks++;
        if ({err_wr_ovf, err_wr_unf, err_proto} !== 3'b000) begin
            $display("FAIL basic_errs ovf=%0b unf=%0b proto=%0b expected 000", err_wr_ovf, err_wr_unf,
                     err_proto);
            errors++;
        end
        checks++;
    endtask

    task automatic test_fifo_order();
        logic early, hit, held;
        logic [63:0] data;
        logic v1, v2, v3, v4;
        logic [63:0] d2, d3;
        for (int i = 0; i < 4; i++) begin
            array_caddr_vld_wr = 1'b1;
            array_caddr_wr     = 6'(i);
            step();
        end
        array_caddr_wr = 6'd9;
        step();
        clear_strobes();
        if (err_wr_ovf !== 1'b1) begin
            $display("FAIL fifo_overflow ovf=%0b expected 1", err_wr_ovf);
            errors++;
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            array_wdata_vld = 1'b1;
            array_wdata     = 64'h100 + 64'(i);
            step();
        end
        clear_strobes();
        for (int i = 0; i < 4; i++) begin
            read_col(6'(i), early, hit, data, held);
            if (early || !hit || data !== 64'h100 + 64'(i)) begin
                $display("FAIL fifo_col%0d early=%0b vld=%0b data=%h expected %h", i, early, hit, data,
                         64'h100 + 64'(i));
                errors++;
            end
            checks++;
        end
        // Back-to-back reads of cols 0 and 1 give adjacent pulses.
        array_caddr_vld_rd = 1'b1;
        array_caddr_rd     = 6'd0;
        step();
        v1 = array_rdata_vld;
        array_caddr_rd = 6'd1;
        step();
        array_caddr_vld_rd = 1'b0;
        v2 = array_rdata_vld;
        d2 = array_rdata;
        step();
        v3 = array_rdata_vld;
        d3 = array_rdata;
        step();
        v4 = array_rdata_vld;
        if ({v1, v2, v3, v4} !== 4'b0110 || d2 !== 64'h100 || d3 !== 64'h101) begin
            $display("FAIL back_to_back vld_seq=%b d0=%h d1=%h expected 0110 100 101", {v1, v2, v3, v4},
                     d2, d3);
            errors++;
        end
        checks++;
        // Full FIFO: push and pop in one cycle must both take effect.
        for (int i = 10; i < 14; i++) begin
            array_caddr_vld_wr = 1'b1;
            array_caddr_wr     = 6'(i);
            step();
        end
        array_caddr_wr  = 6'd14;
        array_wdata_vld = 1'b1;
        array_wdata     = 64'h20A;
        step();
        array_caddr_vld_wr = 1'b0;
        for (int i = 11; i < 15; i++) begin
            array_wdata = 64'h200 + 64'(i);
            step();
        end
        clear_strobes();
        read_col(6'd14, early, hit, data, held);
        if (!hit || data !== 64'h20E) begin
            $display("FAIL full_push_pop vld=%0b data=%h expected 20e", hit, data);
            errors++;
        end
        checks++;
        if (err_wr_unf !== 1'b0) begin
            $display("FAIL fifo_no_unf unf=%0b expected 0", err_wr_unf);
            errors++;
        end
        checks++;
        close_row();
    endtask

    task automatic test_row_alias();
        logic early, hit, held;
        logic [63:0] data;
        open_row(16'h0004);
        write_col(6'd0, 64'h11);
        close_row();
        open_row(16'h0000);
        read_col(6'd0, early, hit, data, held);
        if (!hit || data !== 64'h11) begin
            $display("FAIL row_alias vld=%0b data=%h expected 11", hit, data);
            errors++;
        end
        checks++;
        close_row();
    endtask

    task automatic test_read_during_write();
        logic early, hit, held;
        logic [63:0] data;
        open_row(16'h0002);
        write_col(6'd7, 64'h22);
        array_caddr_vld_rd = 1'b1;
        array_caddr_rd     = 6'd7;
        write_col(6'd7, 64'h33);
        array_caddr_vld_rd = 1'b0;
        step();
        if (!array_rdata_vld || array_rdata !== 64'h22) begin
            $display("FAIL rd_during_wr vld=%0b data=%h expected 22", array_rdata_vld, array_rdata);
            errors++;
        end
        checks++;
        read_col(6'd7, early, hit, data, held);
        if (!hit || data !== 64'h33) begin
            $display("FAIL rd_after_wr vld=%0b data=%h expected 33", hit, data);
            errors++;
        end
        checks++;
        close_row();
        if (err_wr_unf !== 1'b0 || err_proto !== 1'b0) begin
            $display("FAIL clean_errs unf=%0b proto=%0b expected 0 0", err_wr_unf, err_proto);
            errors++;
        end
        checks++;
    endtask

    task automatic test_flush_underflow();
        apply_reset();
        open_row(16'h0001);
        array_caddr_vld_wr = 1'b1;
        array_caddr_wr     = 6'd20;
        step();
        clear_strobes();
        close_row();
        if ({err_wr_ovf, err_wr_unf, err_proto} !== 3'b010) begin
            $display("FAIL flush_unf ovf=%0b unf=%0b proto=%0b expected 010", err_wr_ovf, err_wr_unf,
                     err_proto);
            errors++;
        end
        checks++;
    endtask

    task automatic test_wdata_underflow();
        logic early, hit, held;
        logic [63:0] data;
        apply_reset();
        open_row(16'h0001);
        array_wdata_vld = 1'b1;
        array_wdata     = 64'hDEAD;
        step();
        clear_strobes();
        if (err_wr_unf !== 1'b1) begin
            $display("FAIL wdata_unf unf=%0b expected 1", err_wr_unf);
            errors++;
        end
        checks++;
        read_col(6'd5, early, hit, data, held);
        if (!hit || data !== 64'hA5A5_0000_0000_5A5A) begin
            $display("FAIL storage_kept vld=%0b data=%h expected a5a500000000 5a5a", hit, data);
            errors++;
        end
        checks++;
        close_row();
    endtask

    task automatic test_proto();
        logic seen;
        apply_reset();
        array_caddr_vld_rd = 1'b1;
        array_caddr_rd     = 6'd5;
        step();
        clear_strobes();
        seen = array_rdata_vld;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | array_rdata_vld;
        end
        if (seen !== 1'b0 || err_proto !== 1'b1) begin
            $display("FAIL rd_outside_row vld_seen=%0b proto=%0b expected 0 1", seen, err_proto);
            errors++;
        end
        checks++;
        apply_reset();
        open_row(16'h0001);
        array_cs_n = 1'b1;
        step();
        array_cs_n = 1'b0;
        step();
        if (err_proto !== 1'b1) begin
            $display("FAIL cs_in_precharge proto=%0b expected 1", err_proto);
            errors++;
        end
        checks++;
        array_cs_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset_mid_read();
        logic seen;
        apply_reset();
        open_row(16'h0001);
        array_caddr_vld_rd = 1'b1;
        array_caddr_rd     = 6'd5;
        step();
        clear_strobes();
        rst_n = 1'b0;
        step();
        if ({array_rdata_vld, array_rdata, err_wr_ovf, err_wr_unf, err_proto} !== 68'd0) begin
            $display("FAIL reset_mid_read vld=%0b rdata=%h ovf=%0b unf=%0b proto=%0b expected all 0",
                     array_rdata_vld, array_rdata, err_wr_ovf, err_wr_unf, err_proto);
            errors++;
        end
        checks++;
        rst_n      = 1'b1;
        array_cs_n = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | array_rdata_vld;
        end
        if (seen !== 1'b0) begin
            $display("FAIL dropped_read vld_seen=%0b expected 0", seen);
            errors++;
        end
        checks++;
    endtask

    initial begin
        rst_n          = 1'b0;
        array_cs_n     = 1'b1;
        array_raddr    = '0;
        array_caddr_wr = '0;
        array_caddr_rd = '0;
        array_wdata    = '0;
        clear_strobes();
        test_reset();
        test_basic_bypass();
        test_fifo_order();
        test_row_alias();
        test_read_during_write();
        test_flush_underflow();
        test_wdata_underflow();
        test_proto();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
